// File: rtl/prio_encoder_queue_if.sv
// Output handshake bundle for prio_encoder_queue: valid/ready plus granted index.
// Latency: none, wires only.
// Backpressure: the consumer drives out_ready; the producer holds out_valid/out_idx until accepted.
interface prio_encoder_queue_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;

  // Producer side: the encoder presents an index and waits for ready.
  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  // Consumer side: takes the index when it raises ready.
  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/prio_encoder_queue.sv
// Sticky event capture with one-index-per-transfer encoder; MODE 0 fixed priority (highest wins), MODE 1 round-robin.
// Latency: event sampled at edge k, index valid after edge k+1; one index per cycle with ready held high.
// Backpressure: out_valid/out_idx hold while !out_ready; new events keep merging into pending. Optional macro PRIO_ENC_OVF_CNT_EN adds ovf_cnt.
module prio_encoder_queue #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            evt_i,
  prio_encoder_queue_if.master    out,
  output logic [N-1:0]            pending_o,
  output logic                    ovf
`ifdef PRIO_ENC_OVF_CNT_EN
  ,
  output logic [7:0]              ovf_cnt
`endif
);

  localparam int W = $clog2(N);

  logic [N-1:0] pending_q, pending_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] sel;
  logic [W-1:0] scan;
  logic [N-1:0] clear_mask;
  logic         load;

  // Pick one pending source; the last match written wins, so loop order encodes priority.
  always_comb begin
    sel  = '0;
    scan = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) sel = W'(i);
      end
    end else begin
      // Walk from farthest to nearest so rr_ptr+1 ends up with the final say.
      for (int k = N; k >= 1; k--) begin
        scan = W'((int'(rr_ptr_q) + k) % N);
        if (pending_q[scan]) sel = scan;
      end
    end
  end

  // Output stage update, pending merge and overflow detection.
  always_comb begin
    load       = (|pending_q) && (!valid_q || out.out_ready);
    clear_mask = '0;
    valid_d    = valid_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      clear_mask[sel] = 1'b1;
      valid_d         = 1'b1;
      idx_d           = sel;
      if (MODE == 1) rr_ptr_d = sel;
    end else if (valid_q && out.out_ready) begin
      // Drained: drop valid but keep the last index visible.
      valid_d = 1'b0;
    end
    // An event on the bit being granted this cycle is a fresh event, not an overflow.
    ovf_d     = |(evt_i & pending_q & ~clear_mask);
    pending_d = (pending_q & ~clear_mask) | evt_i;
  end

  // State registers; reset drops any in-flight index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      rr_ptr_q  <= W'(N - 1);
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef PRIO_ENC_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Saturating overflow counter, moves in step with the ovf pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= 8'd0;
    end else if (ovf_d && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign out.out_valid = valid_q;
  assign out.out_idx   = idx_q;
  assign pending_o     = pending_q;
  assign ovf           = ovf_q;

endmodule
